// File: rtl/servo_pkg.sv
// Shared types and helpers for the multi-channel servo ramp generator.
package servo_pkg;

  localparam int POS_W = 32;

  typedef enum logic [2:0] {
    S_MAN,
    S_RISE,
    S_DWELL_HI,
    S_FALL,
    S_DWELL_LO
  } servo_state_t;

  function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] v,
                                             input logic [POS_W-1:0] lo,
                                             input logic [POS_W-1:0] hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/servo_multi_ramp_if.sv
// Host-side target write bus for servo_multi_ramp.
interface servo_multi_ramp_if;
  import servo_pkg::*;

  logic             tgt_wr;
  logic [3:0]       tgt_ch;
  logic [POS_W-1:0] tgt_pos;

  modport master (output tgt_wr, tgt_ch, tgt_pos);
  modport slave  (input  tgt_wr, tgt_ch, tgt_pos);
endinterface

// File: rtl/servo_ramp_ch.sv
// One servo channel: target/current/latched width, slew-limited ramp, PWM compare.
module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter int DUTY_MIN = 25_000,
  parameter int STEP     = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wrap,
  input  logic [POS_W-1:0] phase,
  input  logic             wr_en,
  input  logic [POS_W-1:0] wr_val,
  input  logic             load_en,
  input  logic [POS_W-1:0] load_val,
  input  logic             freeze,
  output logic             servo_out,
  output logic             busy
);

  localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(STEP);
  localparam logic [POS_W-1:0]      STEP_U = POS_W'(STEP);
  localparam logic [POS_W-1:0]      DMIN_U = POS_W'(DUTY_MIN);

  logic [POS_W-1:0] tgt;
  logic [POS_W-1:0] cur;
  logic [POS_W-1:0] pos_q;

  function automatic logic [POS_W-1:0] ramp_step(input logic [POS_W-1:0] c,
                                                 input logic [POS_W-1:0] t);
    logic signed [POS_W:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, c});
    if (d > STEP_S) return c + STEP_U;
    else if (d < -STEP_S) return c - STEP_U;
    else return t;
  endfunction

  assign busy = (cur != tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt       <= DMIN_U;
      cur       <= DMIN_U;
      pos_q     <= DMIN_U;
      servo_out <= 1'b0;
    end else begin
      servo_out <= (phase < pos_q);
      if (wrap) pos_q <= cur;
      // A freeze retargets to the present position, so the step that frame is a no-op.
      if (tick && !freeze) cur <= ramp_step(cur, tgt);
      if (freeze) tgt <= cur;
      else if (load_en) tgt <= load_val;
      else if (wr_en) tgt <= wr_val;
    end
  end

endmodule

// File: rtl/servo_multi_ramp.sv
// N_CH slew-limited hobby-servo PWM outputs on a shared frame, with manual targets or auto sweep.
// Optional build macro SERVO_STAGGER_EN phase-shifts each channel's pulse across the frame.
module servo_multi_ramp
  import servo_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int PERIOD       = 500_000,
  parameter int N_CH         = 4,
  parameter int DUTY_MIN     = PERIOD / 20,
  parameter int DUTY_MAX     = PERIOD / 10,
  parameter int STEP         = 250,
  parameter int DWELL_FRAMES = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_auto,
  servo_multi_ramp_if.slave  host,
  output logic [N_CH-1:0]    servo_out,
  output logic [N_CH-1:0]    busy,
  output logic               frame_tick
);

  if (!(CLK_FREQ > 0 && DUTY_MIN < DUTY_MAX && DUTY_MAX < PERIOD && STEP >= 1 &&
        N_CH >= 1 && N_CH <= 16 && DWELL_FRAMES >= 1)) begin : g_bad_params
    $error("servo_multi_ramp: illegal parameter combination");
  end

  localparam logic [POS_W-1:0] LAST       = POS_W'(PERIOD - 1);
  localparam logic [POS_W-1:0] DMIN_U     = POS_W'(DUTY_MIN);
  localparam logic [POS_W-1:0] DMAX_U     = POS_W'(DUTY_MAX);
  localparam logic [POS_W-1:0] DWELL_LAST = POS_W'(DWELL_FRAMES - 1);

  logic [POS_W-1:0] frame_cnt;
  logic [POS_W-1:0] cnt_next;

  assign cnt_next = (frame_cnt == LAST) ? '0 : frame_cnt + POS_W'(1);

  // frame_tick is registered from the next count so it lines up with frame_cnt == PERIOD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= cnt_next;
      frame_tick <= (cnt_next == LAST);
    end
  end

  servo_state_t     state;
  logic [POS_W-1:0] dwell_cnt;
  logic             load_en;
  logic [POS_W-1:0] load_val;
  logic             freeze;
  logic             all_idle;
  logic             dwell_done;
  logic             leave_auto;

  assign all_idle   = ~|busy;
  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign leave_auto = (state != S_MAN) && !mode_auto;

  always_comb begin
    load_en  = 1'b0;
    load_val = DMIN_U;
    freeze   = 1'b0;
    if (frame_tick) begin
      if (leave_auto) begin
        freeze = 1'b1;
      end else begin
        case (state)
          S_MAN:      if (mode_auto) begin load_en = 1'b1; load_val = DMAX_U; end
          S_DWELL_HI: if (dwell_done) begin load_en = 1'b1; load_val = DMIN_U; end
          S_DWELL_LO: if (dwell_done) begin load_en = 1'b1; load_val = DMAX_U; end
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_MAN;
      dwell_cnt <= '0;
    end else if (frame_tick) begin
      if (leave_auto) begin
        state <= S_MAN;
      end else begin
        case (state)
          S_MAN:      if (mode_auto) state <= S_RISE;
          S_RISE:     if (all_idle) begin state <= S_DWELL_HI; dwell_cnt <= '0; end
          S_DWELL_HI: if (dwell_done) state <= S_FALL;
                      else dwell_cnt <= dwell_cnt + POS_W'(1);
          S_FALL:     if (all_idle) begin state <= S_DWELL_LO; dwell_cnt <= '0; end
          S_DWELL_LO: if (dwell_done) state <= S_RISE;
                      else dwell_cnt <= dwell_cnt + POS_W'(1);
          default:    state <= S_MAN;
        endcase
      end
    end
  end

  logic [POS_W-1:0] wr_val;
  assign wr_val = clamp(host.tgt_pos, DMIN_U, DMAX_U);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [POS_W-1:0] phase;
    logic             wrap;
    logic             wr_en;

    // Out-of-range channel indices never match, so they are silently dropped.
    assign wr_en = host.tgt_wr && (state == S_MAN) && (host.tgt_ch == 4'(i));

`ifdef SERVO_STAGGER_EN
    localparam logic [POS_W:0] OFF = (POS_W+1)'(i * (PERIOD / N_CH));
    logic [POS_W:0] sum;
    assign sum   = {1'b0, frame_cnt} + OFF;
    assign phase = (sum >= (POS_W+1)'(PERIOD)) ? POS_W'(sum - (POS_W+1)'(PERIOD))
                                               : POS_W'(sum);
    assign wrap  = (phase == LAST);
`else
    assign phase = frame_cnt;
    assign wrap  = frame_tick;
`endif

    servo_ramp_ch #(
      .DUTY_MIN (DUTY_MIN),
      .STEP     (STEP)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (frame_tick),
      .wrap      (wrap),
      .phase     (phase),
      .wr_en     (wr_en),
      .wr_val    (wr_val),
      .load_en   (load_en),
      .load_val  (load_val),
      .freeze    (freeze),
      .servo_out (servo_out[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_servo_multi_ramp.sv
// Self-checking bench for servo_multi_ramp: frame-level behavioural model plus literal pulse-width checks.
module tb_servo_multi_ramp;

  localparam int PERIOD = 100;
  localparam int DMIN   = 5;
  localparam int DMAX   = 10;
  localparam int STEP   = 2;
  localparam int DWELL  = 3;
  localparam int NCH    = 2;

  localparam int MAN = 0, RISE = 1, DHI = 2, FALL = 3, DLO = 4;

`ifdef SERVO_STAGGER_EN
  localparam logic [1:0] EARLY_HI = 2'b01;
  localparam int         RISE_GAP = 50;
`else
  localparam logic [1:0] EARLY_HI = 2'b11;
  localparam int         RISE_GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_auto = 1'b0;
  logic [NCH-1:0] servo_out;
  logic [NCH-1:0] busy;
  logic frame_tick;

  servo_multi_ramp_if bus ();

  servo_multi_ramp #(
    .CLK_FREQ(25_000_000), .PERIOD(PERIOD), .N_CH(NCH), .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX), .STEP(STEP), .DWELL_FRAMES(DWELL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_auto(mode_auto), .host(bus),
    .servo_out(servo_out), .busy(busy), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (frame-level rules) ----------------
  int m_cnt;
  int m_cur[NCH];
  int m_tgt[NCH];
  int m_pos[NCH];
  logic [NCH-1:0] m_out;
  int m_mode;
  int m_dw;

  function automatic int offs(input int i);
`ifdef SERVO_STAGGER_EN
    return i * (PERIOD / NCH);
`else
    return 0 * i;
`endif
  endfunction

  function automatic int clampi(input logic [31:0] v);
    if (v < DMIN) return DMIN;
    if (v > DMAX) return DMAX;
    return int'(v);
  endfunction

  function automatic int toward(input int c, input int t);
    if (t - c > STEP) return c + STEP;
    if (c - t > STEP) return c - STEP;
    return t;
  endfunction

  function automatic logic [NCH-1:0] m_busy();
    logic [NCH-1:0] b;
    for (int i = 0; i < NCH; i++) b[i] = (m_cur[i] != m_tgt[i]);
    return b;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = MAN; m_dw = 0; m_out = '0;
    for (int i = 0; i < NCH; i++) begin m_cur[i] = DMIN; m_tgt[i] = DMIN; m_pos[i] = DMIN; end
  endtask

  task automatic model_step();
    int nc[NCH];
    int nt[NCH];
    bit tick;
    bit moving;
    int ph;
    tick = (m_cnt == PERIOD - 1);
    moving = (m_busy() != '0);
    for (int i = 0; i < NCH; i++) begin
      ph = (m_cnt + offs(i)) % PERIOD;
      m_out[i] = (ph < m_pos[i]);
      if (ph == PERIOD - 1) m_pos[i] = m_cur[i];
      nc[i] = tick ? toward(m_cur[i], m_tgt[i]) : m_cur[i];
      nt[i] = m_tgt[i];
    end
    if (bus.tgt_wr && m_mode == MAN && bus.tgt_ch < NCH) nt[bus.tgt_ch] = clampi(bus.tgt_pos);
    if (tick) begin
      if (m_mode != MAN && !mode_auto) begin
        for (int i = 0; i < NCH; i++) begin nt[i] = m_cur[i]; nc[i] = m_cur[i]; end
        m_mode = MAN;
      end else begin
        case (m_mode)
          MAN:  if (mode_auto) begin for (int i = 0; i < NCH; i++) nt[i] = DMAX; m_mode = RISE; end
          RISE: if (!moving) begin m_mode = DHI; m_dw = 0; end
          DHI:  if (m_dw == DWELL - 1) begin for (int i = 0; i < NCH; i++) nt[i] = DMIN; m_mode = FALL; end
                else m_dw++;
          FALL: if (!moving) begin m_mode = DLO; m_dw = 0; end
          DLO:  if (m_dw == DWELL - 1) begin for (int i = 0; i < NCH; i++) nt[i] = DMAX; m_mode = RISE; end
                else m_dw++;
          default: ;
        endcase
      end
    end
    for (int i = 0; i < NCH; i++) begin m_cur[i] = nc[i]; m_tgt[i] = nt[i]; end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- per-cycle comparison ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("servo_out", 64'(servo_out), 64'(m_out));
      chk("busy", 64'(busy), 64'(m_busy()));
      chk("frame_tick", 64'(frame_tick), 64'(m_cnt == PERIOD - 1));
    end
  end

  // ---------------- pulse-width / edge monitor ----------------
  longint cyc = 0;
  int wcnt[NCH];
  int wq0[$];
  int wq1[$];
  longint tick_cyc[$];
  longint rise_c[NCH];
  logic [NCH-1:0] prev_out = '0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) wcnt[i] = 0;
      prev_out = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (servo_out[i]) wcnt[i]++;
        if (servo_out[i] && !prev_out[i]) rise_c[i] = cyc;
      end
      prev_out = servo_out;
      if (frame_tick) begin
        wq0.push_back(wcnt[0]);
        wq1.push_back(wcnt[1]);
        for (int i = 0; i < NCH; i++) wcnt[i] = 0;
        tick_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int budget = n * PERIOD + 10;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (frame_tick) seen++;
      budget--;
    end
    if (seen < n) chk("wait_ticks_timeout", 64'(seen), 64'(n));
  endtask

  task automatic write(input int ch, input logic [31:0] pos);
    @(negedge clk);
    bus.tgt_wr = 1'b1; bus.tgt_ch = 4'(ch); bus.tgt_pos = pos;
    @(negedge clk);
    bus.tgt_wr = 1'b0;
  endtask

  int k;
  int exp_wr[6]   = '{5, 5, 7, 9, 10, 10};
  int exp_auto[19] = '{5, 5, 5, 7, 9, 10, 10, 10, 10, 10, 8, 6, 5, 5, 5, 5, 5, 7, 7};

  initial begin
    bus.tgt_wr = 1'b0; bus.tgt_ch = '0; bus.tgt_pos = '0;
    model_reset();
    cycles(3);
    chk("reset_servo_out", 64'(servo_out), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_frame_tick", 64'(frame_tick), 64'(0));
    rst_n = 1'b1;

    // Idle manual frames
    wait_ticks(3);
    chk("idle_w0", 64'(wq0[$]), 64'(5));
    chk("idle_w1", 64'(wq1[$]), 64'(5));
    chk("tick_interval", 64'(tick_cyc[$] - tick_cyc[$-1]), 64'(PERIOD));
    chk("idle_busy", 64'(busy), 64'(0));

    // Mid-frame write ch0=10
    cycles(50);
    k = wq0.size();
    write(0, 10);
    wait_ticks(6);
    for (int j = 0; j < 6; j++) chk("ramp_w0", 64'(wq0[k + j]), 64'(exp_wr[j]));
    chk("ramp_busy_done", 64'(busy[0]), 64'(0));

    // Clamping and out-of-range channel
    cycles(30);
    write(1, 200);
    wait_ticks(5);
    chk("clamp_hi_w1", 64'(wq1[$]), 64'(10));
    write(1, 0);
    wait_ticks(5);
    chk("clamp_lo_w1", 64'(wq1[$]), 64'(5));
    write(3, 8);
    wait_ticks(3);
    chk("bad_ch_w0", 64'(wq0[$]), 64'(10));
    chk("bad_ch_w1", 64'(wq1[$]), 64'(5));

    // Randomized writes with occasional auto excursions
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.tgt_wr  = ($urandom % 6 == 0);
      bus.tgt_ch  = 4'($urandom % 4);
      bus.tgt_pos = ($urandom % 4 == 0) ? 32'($urandom) : 32'($urandom_range(0, 14));
      if ($urandom % 400 == 0) mode_auto = ~mode_auto;
    end
    @(negedge clk);
    bus.tgt_wr = 1'b0;
    mode_auto = 1'b0;
    wait_ticks(2);

    // Settle both channels at DMIN, then run the auto sweep
    cycles(20);
    write(0, 5);
    write(1, 5);
    wait_ticks(5);
    cycles(50);
    k = wq0.size();
    mode_auto = 1'b1;
    wait_ticks(16);
    cycles(50);
    mode_auto = 1'b0;
    wait_ticks(3);
    for (int j = 0; j < 19; j++) chk("auto_w0", 64'(wq0[k + j]), 64'(exp_auto[j]));
    chk("freeze_busy", 64'(busy), 64'(0));

    // Asynchronous reset during a pulse at frame_cnt == 3
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_out", 64'(servo_out), 64'(EARLY_HI));
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", 64'(servo_out), 64'(0));
    chk("async_reset_tick", 64'(frame_tick), 64'(0));
    chk("async_reset_busy", 64'(busy), 64'(0));
    cycles(3);
    rst_n = 1'b1;
    k = wq0.size();
    @(posedge clk);
    #2;
    chk("release_first_out", 64'(servo_out), 64'(EARLY_HI));
    wait_ticks(1);
    chk("release_w0", 64'(wq0[k]), 64'(5));
    chk("release_w1", 64'(wq1[k]), 64'(5));
    chk("rise_gap", 64'(rise_c[1] - rise_c[0]), 64'(RISE_GAP));

    cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
